ctrl_fetch_stage: RTL
=====================

CTRL_FETCH_STAGE -- requirements
Module: ctrl_fetch_stage

Interface
REQ-001 Parameter PROG_CTR_WID, default 10, program-counter and instruction-address width.
REQ-002 Parameter INSTR_WID, default 16, instruction word width.
REQ-003 Parameter FIFO_DEPTH, default 4, fetch buffer entries, power of two, at least 2.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 prog_ctr  input  PROG_CTR_WID  current fetch address from program counter.
REQ-007 set_invalidate_instruction  input  1  flush: in-flight wrong-path fetches are discarded.
REQ-008 imem_addr  output  PROG_CTR_WID  instruction memory address.
REQ-009 imem_rdata  input  INSTR_WID  instruction memory data, valid one cycle after imem_addr.
REQ-010 out_valid  output  1  head entry valid toward decode.
REQ-011 out_ready  input  1  decode accepts head entry this cycle.
REQ-012 out_instr  output  INSTR_WID  head entry instruction.
REQ-013 out_pc  output  PROG_CTR_WID  head entry fetch address.
REQ-014 out_pc_plus1  output  PROG_CTR_WID  out_pc+1 modulo 2^PROG_CTR_WID, feeds branch/next-PC logic.
REQ-015 fetch_stall_req  output  1  advisory: buffer nearly full.
REQ-016 fifo_count  output  log2(FIFO_DEPTH)+1  current occupancy.
REQ-017 overflow_err  output  1  sticky: a fetched instruction was dropped because the buffer was full.

Function
REQ-018 imem_addr SHALL equal prog_ctr combinationally.
REQ-019 The block SHALL register the request: req_pc_d1 <= prog_ctr, req_vld_d1 <= 1 every non-reset cycle.
REQ-020 A response SHALL be pushed in cycle t+1 for an address issued in cycle t, entry = {imem_rdata, req_pc_d1}, when req_vld_d1=1 and set_invalidate_instruction=0.
REQ-021 Buffer SHALL be in-order FIFO; outputs driven from head storage; out_valid = (fifo_count != 0).
REQ-022 Pop SHALL occur when out_valid=1 and out_ready=1; out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 Address-to-out_valid latency SHALL be 2 cycles with an empty buffer (issue t, data t+1, visible t+2).
REQ-024 Push and pop in the same cycle SHALL both take effect, count unchanged, including when full.
REQ-025 Push when full without pop SHALL drop the response, leave the buffer unchanged, and set overflow_err to 1.
REQ-026 Flush (set_invalidate_instruction=1) SHALL override push and pop: buffer cleared, fifo_count -> 0, response arriving that cycle discarded; address issued that cycle (branch target) SHALL be fetched normally.
REQ-027 Consecutive flush cycles SHALL each clear the buffer and discard that cycle's response.
REQ-028 fetch_stall_req SHALL be 1 when fifo_count >= FIFO_DEPTH-1, combinational from count.
REQ-029 out_pc_plus1 SHALL wrap from 2^PROG_CTR_WID-1 to 0.
REQ-030 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 overflow_err SHALL clear only on reset; flush SHALL not clear it.

Reset
REQ-032 On reset: fifo_count=0, pointers=0, req_vld_d1=0, req_pc_d1=0, overflow_err=0; out_valid=0, fetch_stall_req=0.
REQ-033 Reset mid-operation SHALL discard all buffered entries and any in-flight response within the same edge.
REQ-034 First cycle after reset: response from the reset cycle SHALL NOT be pushed (req_vld_d1=0).

Verification
REQ-035 Reset then out_ready=1, prog_ctr 1,2,3, memory[n]=0x1000+n -> out_valid first at cycle 3, out_pc=1, out_instr=0x1001, out_pc_plus1=2, then 2,3 on consecutive cycles.
REQ-036 out_ready=0 with FIFO_DEPTH=4 streaming -> fifo_count 1,2,3,4; fetch_stall_req rises at count 3; fifth response sets overflow_err=1, count stays 4, head still pc=1.
REQ-037 Full buffer, out_ready=1 with a response arriving -> count stays 4, head advances to pc=2, overflow_err unchanged.
REQ-038 Count=3, set_invalidate_instruction=1 with prog_ctr=0x040 -> next cycle count=0, out_valid=0; two cycles later out_pc=0x040.
REQ-039 prog_ctr=0x3FF (PROG_CTR_WID=10) -> out_pc=0x3FF, out_pc_plus1=0x000.
REQ-040 Reset asserted with count=2 and overflow_err=1 -> next cycle count=0, overflow_err=0, out_valid=0, no push that cycle.

Source files
------------

// File: rtl/ctrl_fetch_stage_if.sv
// Fetch-stage bundle: program-counter request, instruction memory port,
// decode-side handshake and buffer status.
interface ctrl_fetch_stage_if #(
    parameter int PROG_CTR_WID = 10,
    parameter int INSTR_WID    = 16,
    parameter int FIFO_DEPTH   = 4
);
    localparam int CNT_WID = $clog2(FIFO_DEPTH) + 1;

    logic [PROG_CTR_WID-1:0] prog_ctr;
    logic                    set_invalidate_instruction;
    logic [PROG_CTR_WID-1:0] imem_addr;
    logic [INSTR_WID-1:0]    imem_rdata;
    logic                    out_valid;
    logic                    out_ready;
    logic [INSTR_WID-1:0]    out_instr;
    logic [PROG_CTR_WID-1:0] out_pc;
    logic [PROG_CTR_WID-1:0] out_pc_plus1;
    logic                    fetch_stall_req;
    logic [CNT_WID-1:0]      fifo_count;
    logic                    overflow_err;

    // Fetch stage side
    modport slave (
        input  prog_ctr, set_invalidate_instruction, imem_rdata, out_ready,
        output imem_addr, out_valid, out_instr, out_pc, out_pc_plus1,
               fetch_stall_req, fifo_count, overflow_err
    );

    // Program counter / memory / decode side
    modport master (
        output prog_ctr, set_invalidate_instruction, imem_rdata, out_ready,
        input  imem_addr, out_valid, out_instr, out_pc, out_pc_plus1,
               fetch_stall_req, fifo_count, overflow_err
    );
endinterface

// File: rtl/ctrl_fetch_stage.sv
// Instruction fetch stage: issues prog_ctr straight to instruction memory,
// captures the response one cycle later into an in-order buffer and presents
// the head entry to decode with a valid/ready handshake. A flush empties the
// buffer and throws away the wrong-path response landing in that cycle, while
// the address issued alongside the flush (the branch target) is still fetched.
module ctrl_fetch_stage #(
    parameter int PROG_CTR_WID = 10,
    parameter int INSTR_WID    = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset,
    ctrl_fetch_stage_if.slave   bus
);
    localparam int PTR_WID = $clog2(FIFO_DEPTH);
    localparam int CNT_WID = PTR_WID + 1;
    localparam logic [CNT_WID-1:0] CNT_FULL  = CNT_WID'(FIFO_DEPTH);
    localparam logic [CNT_WID-1:0] CNT_STALL = CNT_WID'(FIFO_DEPTH - 1);

    logic [PROG_CTR_WID-1:0] req_pc_q, req_pc_d;
    logic                    req_vld_q, req_vld_d;
    logic [PTR_WID-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_WID-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_WID-1:0]      count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic [INSTR_WID-1:0]    instr_mem_q [FIFO_DEPTH];
    logic [INSTR_WID-1:0]    instr_mem_d [FIFO_DEPTH];
    logic [PROG_CTR_WID-1:0] pc_mem_q    [FIFO_DEPTH];
    logic [PROG_CTR_WID-1:0] pc_mem_d    [FIFO_DEPTH];

    logic flush;
    logic full;
    logic push_req;
    logic push;
    logic pop;

    assign flush = bus.set_invalidate_instruction;
    assign full  = (count_q == CNT_FULL);

    // Next-state: request pipeline, buffer push/pop/flush and sticky overflow
    always_comb begin
        req_pc_d    = bus.prog_ctr;
        req_vld_d   = 1'b1;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;

        push_req = req_vld_q && !flush;
        pop      = (count_q != '0) && bus.out_ready && !flush;
        // A full buffer still accepts the response when the head leaves in the same cycle
        push     = push_req && (!full || pop);

        overflow_d = overflow_q | (push_req & full & ~pop);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                instr_mem_d[wr_ptr_q] = bus.imem_rdata;
                pc_mem_d[wr_ptr_q]    = req_pc_q;
                wr_ptr_d              = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            req_pc_q   <= '0;
            req_vld_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            req_pc_q    <= req_pc_d;
            req_vld_q   <= req_vld_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            instr_mem_q <= instr_mem_d;
            pc_mem_q    <= pc_mem_d;
        end
    end

    assign bus.imem_addr       = bus.prog_ctr;
    assign bus.out_valid       = (count_q != '0);
    assign bus.out_instr       = instr_mem_q[rd_ptr_q];
    assign bus.out_pc          = pc_mem_q[rd_ptr_q];
    assign bus.out_pc_plus1    = pc_mem_q[rd_ptr_q] + PROG_CTR_WID'(1);
    assign bus.fetch_stall_req = (count_q >= CNT_STALL);
    assign bus.fifo_count      = count_q;
    assign bus.overflow_err    = overflow_q;
endmodule
